mux_arb_2to1: RTL



---
 rtl/mux_arb_2to1.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mux_arb_2to1.sv
// mux_arb_2to1
// Two-lane buffered round-robin arbiter in front of the 2:1 byte mux output
// stage. Each lane writes into its own small FIFO. A registered output stage
// pops one byte per cycle from a non-empty FIFO. When both FIFOs hold data it
// alternates between the lanes. It honours downstream backpressure through
// ready_out.
//
// Parameters:
//   DATA_WIDTH  byte width of every data path
//   FIFO_DEPTH  entries per lane FIFO (power of two, >= 2)
//
// Ports:
//   clk         sole clock, rising edge
//   reset       asynchronous active-high reset, clears all state
//   data_in_0   lane 0 byte           valid_in_0  lane 0 byte valid
//   data_in_1   lane 1 byte           valid_in_1  lane 1 byte valid
//   ready_out   downstream accepts data_out this cycle
//   data_out    arbitrated byte (registered)
//   valid_out   data_out holds a byte (registered)
//   sel_out     source lane of data_out (registered)
//   full_0/1    lane FIFO holds FIFO_DEPTH entries
//   drop_0/1    one-cycle pulse: a valid byte was discarded on a full FIFO
module mux_arb_2to1 #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in_0,
  input  logic                  valid_in_0,
  input  logic [DATA_WIDTH-1:0] data_in_1,
  input  logic                  valid_in_1,
  input  logic                  ready_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  sel_out,
  output logic                  full_0,
  output logic                  full_1,
  output logic                  drop_0,
  output logic                  drop_1
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // The arbiter state records which lane won the most recent grant.
  typedef enum logic {
    LAST0 = 1'b0,
    LAST1 = 1'b1
  } arbState_e;

  arbState_e state_q, state_d;

  logic [DATA_WIDTH-1:0] laneData [2];
  logic [1:0]            laneValid;

  logic [DATA_WIDTH-1:0] fifoMem_q [2][FIFO_DEPTH];
  logic [PTR_W-1:0]      wrPtr_q [2];
  logic [PTR_W-1:0]      wrPtr_d [2];
  logic [PTR_W-1:0]      rdPtr_q [2];
  logic [PTR_W-1:0]      rdPtr_d [2];
  logic [CNT_W-1:0]      count_q [2];
  logic [CNT_W-1:0]      count_d [2];

  logic [1:0] full;
  logic [1:0] nonEmpty;
  logic [1:0] wrEn;
  logic [1:0] popEn;
  logic [1:0] drop_q, drop_d;

  logic                  loadOk;
  logic                  grant;
  logic [DATA_WIDTH-1:0] dataOut_q, dataOut_d;
  logic                  validOut_q, validOut_d;
  logic                  selOut_q, selOut_d;

  assign laneData[0] = data_in_0;
  assign laneData[1] = data_in_1;
  assign laneValid   = {valid_in_1, valid_in_0};

  // Lane FIFO bookkeeping. Full is judged on the registered count, so a byte
  // arriving at a full FIFO is dropped even when that FIFO is popped in the
  // same cycle. Pointers wrap for free because the depth is a power of two.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      full[i]     = (count_q[i] == CNT_W'(FIFO_DEPTH));
      nonEmpty[i] = (count_q[i] != '0);
      wrEn[i]     = laneValid[i] && !full[i];
      drop_d[i]   = laneValid[i] && full[i];
      wrPtr_d[i]  = wrPtr_q[i] + PTR_W'(wrEn[i]);
      rdPtr_d[i]  = rdPtr_q[i] + PTR_W'(popEn[i]);
      count_d[i]  = count_q[i] + CNT_W'(wrEn[i]) - CNT_W'(popEn[i]);
    end
  end

  // Arbiter and output-stage next state. The output register may take a new
  // byte when it is empty or being consumed this cycle. Emptiness is judged
  // on the registered count, so a freshly written byte waits one cycle.
  always_comb begin
    state_d    = state_q;
    popEn      = '0;
    grant      = 1'b0;
    dataOut_d  = dataOut_q;
    selOut_d   = selOut_q;
    validOut_d = validOut_q;
    loadOk     = !validOut_q || ready_out;

    // On contention the lane opposite the last grant wins. Otherwise the
    // single non-empty lane is lane 1 exactly when nonEmpty[1] is set.
    if (nonEmpty[0] && nonEmpty[1]) begin
      grant = (state_q == LAST1) ? 1'b0 : 1'b1;
    end else begin
      grant = nonEmpty[1];
    end

    if (loadOk) begin
      if (|nonEmpty) begin
        popEn[grant] = 1'b1;
        state_d      = arbState_e'(grant);
        dataOut_d    = fifoMem_q[grant][rdPtr_q[grant]];
        selOut_d     = grant;
        validOut_d   = 1'b1;
      end else begin
        validOut_d   = 1'b0;
      end
    end
  end

  // FIFO storage carries no reset; the pointers and counts define validity.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (wrEn[i]) begin
        fifoMem_q[i][wrPtr_q[i]] <= laneData[i];
      end
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        wrPtr_q[i] <= '0;
        rdPtr_q[i] <= '0;
        count_q[i] <= '0;
      end
      drop_q     <= '0;
      state_q    <= LAST1;
      dataOut_q  <= '0;
      validOut_q <= 1'b0;
      selOut_q   <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        wrPtr_q[i] <= wrPtr_d[i];
        rdPtr_q[i] <= rdPtr_d[i];
        count_q[i] <= count_d[i];
      end
      drop_q     <= drop_d;
      state_q    <= state_d;
      dataOut_q  <= dataOut_d;
      validOut_q <= validOut_d;
      selOut_q   <= selOut_d;
    end
  end

  assign data_out  = dataOut_q;
  assign valid_out = validOut_q;
  assign sel_out   = selOut_q;
  assign full_0    = full[0];
  assign full_1    = full[1];
  assign drop_0    = drop_q[0];
  assign drop_1    = drop_q[1];

endmodule
